// File: rtl/audio_pkt_pkg.sv
// Shared types and constants for the audio UDP packetiser/depacketiser pair.
package audio_pkt_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPrefill = 2'd1,
        StPlay    = 2'd2
    } play_state_e;

    localparam int unsigned SAMPLE_W          = 16;
    localparam int unsigned MAX_PKT_BYTES_DEF = 1024;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fifo_audio_depkt.sv
// Async FIFO with Gray-coded pointers; registered read data (1-cycle latency) and a
// read-side water level that lags the write side by the pointer synchroniser delay.
module fifo_audio_depkt #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 16
) (
    input  logic          wr_clk,
    input  logic          wr_rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    input  logic          rd_clk,
    input  logic          rd_rst,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic [AW-1:0] rd_water_level
);

    typedef logic [AW:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[AW] = g[AW];
        for (int i = int'(AW) - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DW-1:0] mem [0:(1<<AW)-1];

    ptr_t wbin_q, wgray_q, rgray_wq1, rgray_wq2, wbin_d;
    ptr_t rbin_q, rgray_q, wgray_rq1, wgray_rq2, rbin_d;
    ptr_t fill;
    logic wr_fire, rd_fire;

    assign wr_fire = wr_en && !full;
    assign wbin_d  = wr_fire ? wbin_q + ptr_t'(1) : wbin_q;

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            wbin_q    <= '0;
            wgray_q   <= '0;
            rgray_wq1 <= '0;
            rgray_wq2 <= '0;
        end else begin
            wbin_q    <= wbin_d;
            wgray_q   <= bin2gray(wbin_d);
            rgray_wq1 <= rgray_q;
            rgray_wq2 <= rgray_wq1;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_fire) begin
            mem[wbin_q[AW-1:0]] <= wr_data;
        end
    end

    // Full when the write pointer is exactly one lap ahead of the synced read pointer.
    assign full = (wgray_q == {~rgray_wq2[AW:AW-1], rgray_wq2[AW-2:0]});

    assign rd_fire = rd_en && !empty;
    assign rbin_d  = rd_fire ? rbin_q + ptr_t'(1) : rbin_q;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rbin_q    <= '0;
            rgray_q   <= '0;
            wgray_rq1 <= '0;
            wgray_rq2 <= '0;
            rd_data   <= '0;
        end else begin
            rbin_q    <= rbin_d;
            rgray_q   <= bin2gray(rbin_d);
            wgray_rq1 <= wgray_q;
            wgray_rq2 <= wgray_rq1;
            if (rd_fire) begin
                rd_data <= mem[rbin_q[AW-1:0]];
            end
        end
    end

    assign empty = (rgray_q == wgray_rq2);

    // A completely full FIFO reports the largest representable level.
    assign fill           = gray2bin(wgray_rq2) - rbin_q;
    assign rd_water_level = fill[AW] ? '1 : fill[AW-1:0];

endmodule

// File: rtl/udp_audio_depkt.sv
// UDP payload words -> async FIFO -> one PCM sample per DAC request, with prefill
// gating and underrun recovery.
module udp_audio_depkt
    import audio_pkt_pkg::*;
#(
    parameter int unsigned PREFILL       = 512,
    parameter int unsigned MAX_PKT_BYTES = MAX_PKT_BYTES_DEF,
    parameter int unsigned FIFO_AW       = 11
) (
    input  logic                audio_clk,
    input  logic                rst_n,
    input  logic                eth_rx_clk,
    input  logic                transfer_flag,
    input  logic                udp_rec_en,
    input  logic [31:0]         udp_rec_data,
    input  logic                udp_rec_pkt_done,
    input  logic                audio_req,
    output logic [SAMPLE_W-1:0] audio_data,
    output logic                audio_valid,
    output logic                playing,
    output logic [15:0]         underrun_cnt,
    output logic [15:0]         drop_cnt
);

    localparam int unsigned MAX_WORDS = MAX_PKT_BYTES / 4;
    localparam int unsigned WCNT_W    = $clog2(MAX_WORDS + 1);

    logic [1:0] aud_rst_sync, eth_rst_sync, tf_aud_sync, tf_eth_sync;
    logic       aud_rst_n, eth_rst_n, tf_aud, tf_eth;

    always_ff @(posedge audio_clk or negedge rst_n) begin
        if (!rst_n) aud_rst_sync <= '0;
        else        aud_rst_sync <= {aud_rst_sync[0], 1'b1};
    end

    always_ff @(posedge eth_rx_clk or negedge rst_n) begin
        if (!rst_n) eth_rst_sync <= '0;
        else        eth_rst_sync <= {eth_rst_sync[0], 1'b1};
    end

    assign aud_rst_n = aud_rst_sync[1];
    assign eth_rst_n = eth_rst_sync[1];

    always_ff @(posedge audio_clk or negedge aud_rst_n) begin
        if (!aud_rst_n) tf_aud_sync <= '0;
        else            tf_aud_sync <= {tf_aud_sync[0], transfer_flag};
    end

    always_ff @(posedge eth_rx_clk or negedge eth_rst_n) begin
        if (!eth_rst_n) tf_eth_sync <= '0;
        else            tf_eth_sync <= {tf_eth_sync[0], transfer_flag};
    end

    assign tf_aud = tf_aud_sync[1];
    assign tf_eth = tf_eth_sync[1];

    logic                fifo_full, fifo_empty, wr_en, rd_en;
    logic [SAMPLE_W-1:0] rd_data;
    logic [FIFO_AW-1:0]  rd_water_level;
    logic                unused_upper;

    assign unused_upper = ^udp_rec_data[31:16];

    fifo_audio_depkt #(
        .AW (FIFO_AW),
        .DW (SAMPLE_W)
    ) u_fifo (
        .wr_clk         (eth_rx_clk),
        .wr_rst         (~tf_eth),
        .wr_en          (wr_en),
        .wr_data        (udp_rec_data[SAMPLE_W-1:0]),
        .full           (fifo_full),
        .rd_clk         (audio_clk),
        .rd_rst         (~tf_aud),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .empty          (fifo_empty),
        .rd_water_level (rd_water_level)
    );

    // Ethernet side: per-packet word count and drop accounting.
    logic [WCNT_W-1:0] wcnt_q;
    logic              wcnt_lt_max;

    assign wcnt_lt_max = (wcnt_q < WCNT_W'(MAX_WORDS));
    assign wr_en       = udp_rec_en && tf_eth && !fifo_full && wcnt_lt_max;

    always_ff @(posedge eth_rx_clk or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            wcnt_q   <= '0;
            drop_cnt <= '0;
        end else if (!tf_eth) begin
            wcnt_q   <= '0;
            drop_cnt <= '0;
        end else begin
            if (udp_rec_en && !wr_en) begin
                drop_cnt <= sat_inc16(drop_cnt);
            end
            // The word in a pkt_done cycle was already judged against the old count.
            if (udp_rec_pkt_done) begin
                wcnt_q <= '0;
            end else if (udp_rec_en && wcnt_lt_max) begin
                wcnt_q <= wcnt_q + WCNT_W'(1);
            end
        end
    end

    // Audio side playback FSM.
    play_state_e state_q, state_d;
    logic        req_take, underrun_hit;
    logic        p1_valid_q, p1_fifo_q;

    always_comb begin
        state_d      = state_q;
        rd_en        = 1'b0;
        req_take     = 1'b0;
        underrun_hit = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tf_aud) state_d = StPrefill;
            end
            StPrefill: begin
                req_take = audio_req;
                if (rd_water_level >= FIFO_AW'(PREFILL)) state_d = StPlay;
            end
            StPlay: begin
                if (audio_req) begin
                    req_take = 1'b1;
                    if (!fifo_empty) begin
                        rd_en = 1'b1;
                    end else begin
                        underrun_hit = 1'b1;
                        state_d      = StPrefill;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (!tf_aud) state_d = StIdle;
    end

    always_ff @(posedge audio_clk or negedge aud_rst_n) begin
        if (!aud_rst_n) begin
            state_q      <= StIdle;
            underrun_cnt <= '0;
            p1_valid_q   <= 1'b0;
            p1_fifo_q    <= 1'b0;
            audio_valid  <= 1'b0;
            audio_data   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle) begin
                underrun_cnt <= '0;
            end else if (underrun_hit) begin
                underrun_cnt <= sat_inc16(underrun_cnt);
            end
            p1_valid_q  <= req_take;
            p1_fifo_q   <= rd_en;
            audio_valid <= p1_valid_q;
            // A read caught by a stop still completes its pulse, but as silence.
            if (p1_valid_q) begin
                audio_data <= (p1_fifo_q && tf_aud) ? rd_data : '0;
            end
        end
    end

    assign playing = (state_q == StPlay);

endmodule

// File: tb/tb_udp_audio_depkt.sv
// Directed bench for udp_audio_depkt: prefill, playback order/latency, underrun,
// over-length and full drops, pkt_done collision, and stop/restart.
module tb_udp_audio_depkt;

    logic        audio_clk = 1'b0;
    logic        eth_rx_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        transfer_flag = 1'b0;
    logic        udp_rec_en = 1'b0;
    logic [31:0] udp_rec_data = '0;
    logic        udp_rec_pkt_done = 1'b0;
    logic        audio_req = 1'b0;
    logic [15:0] audio_data;
    logic        audio_valid;
    logic        playing;
    logic [15:0] underrun_cnt;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 audio_clk = ~audio_clk;
    always #4 eth_rx_clk = ~eth_rx_clk;

    udp_audio_depkt dut (
        .audio_clk        (audio_clk),
        .rst_n            (rst_n),
        .eth_rx_clk       (eth_rx_clk),
        .transfer_flag    (transfer_flag),
        .udp_rec_en       (udp_rec_en),
        .udp_rec_data     (udp_rec_data),
        .udp_rec_pkt_done (udp_rec_pkt_done),
        .audio_req        (audio_req),
        .audio_data       (audio_data),
        .audio_valid      (audio_valid),
        .playing          (playing),
        .underrun_cnt     (underrun_cnt),
        .drop_cnt         (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Upper half of each word carries junk that must be ignored.
    task automatic send_pkt(input int n, input int base, input bit done_with_last);
        for (int i = 0; i < n; i++) begin
            @(negedge eth_rx_clk);
            udp_rec_en       = 1'b1;
            udp_rec_data     = {16'hA5A5, 16'(base + i)};
            udp_rec_pkt_done = done_with_last && (i == n - 1);
        end
        @(negedge eth_rx_clk);
        udp_rec_en       = 1'b0;
        udp_rec_data     = '0;
        udp_rec_pkt_done = !done_with_last;
        @(negedge eth_rx_clk);
        udp_rec_pkt_done = 1'b0;
    endtask

    // One request; valid must be low at N+1, high at N+2, low at N+3.
    task automatic do_req(input string tag, input int idle, output logic [15:0] d);
        logic v1, v2, v3;
        @(negedge audio_clk);
        audio_req = 1'b1;
        @(negedge audio_clk);
        audio_req = 1'b0;
        v1 = audio_valid;
        @(negedge audio_clk);
        v2 = audio_valid;
        d  = audio_data;
        @(negedge audio_clk);
        v3 = audio_valid;
        check(tag, {29'd0, v1, v2, v3}, 32'd2);
        repeat (idle) @(negedge audio_clk);
    endtask

    task automatic wait_playing(input string tag);
        for (int i = 0; i < 3000 && !playing; i++) @(negedge audio_clk);
        check(tag, {31'd0, playing}, 32'd1);
    endtask

    task automatic stop_flag();
        transfer_flag = 1'b0;
        repeat (20) @(negedge audio_clk);
    endtask

    task automatic start_flag();
        transfer_flag = 1'b1;
        repeat (10) @(negedge audio_clk);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        int          exp;

        repeat (3) @(negedge audio_clk);
        check("rst_data", {16'd0, audio_data}, 32'd0);
        check("rst_valid", {31'd0, audio_valid}, 32'd0);
        check("rst_playing", {31'd0, playing}, 32'd0);
        check("rst_underrun", {16'd0, underrun_cnt}, 32'd0);
        check("rst_drop", {16'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge audio_clk);

        // Prefill and in-order playback.
        start_flag();
        check("idle_playing", {31'd0, playing}, 32'd0);
        send_pkt(256, 0, 1'b0);
        repeat (50) @(negedge audio_clk);
        check("prefill_partial", {31'd0, playing}, 32'd0);
        send_pkt(256, 256, 1'b0);
        wait_playing("prefill_play");
        for (int i = 0; i < 512; i++) begin
            do_req("play_lat", 4, d);
            check("play_data", {16'd0, d}, 32'(i));
        end
        repeat (3) @(negedge audio_clk);
        check("hold_data", {16'd0, audio_data}, 32'd511);

        // Underrun.
        do_req("ur_lat", 4, d);
        check("ur_data", {16'd0, d}, 32'd0);
        check("ur_cnt", {16'd0, underrun_cnt}, 32'd1);
        check("ur_state", {31'd0, playing}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            do_req("ur_lat2", 4, d);
            check("ur_data2", {16'd0, d}, 32'd0);
            check("ur_cnt2", {16'd0, underrun_cnt}, 32'd1);
        end
        stop_flag();
        check("off_underrun", {16'd0, underrun_cnt}, 32'd0);
        check("off_playing", {31'd0, playing}, 32'd0);
        check("off_drop", {16'd0, drop_cnt}, 32'd0);

        // Over-length packet, then pkt_done on the 257th word, then a 1-word packet.
        start_flag();
        send_pkt(300, 1000, 1'b0);
        repeat (5) @(negedge eth_rx_clk);
        check("ovl_drop", {16'd0, drop_cnt}, 32'd44);
        send_pkt(257, 2000, 1'b1);
        repeat (5) @(negedge eth_rx_clk);
        check("coll_drop", {16'd0, drop_cnt}, 32'd45);
        send_pkt(1, 3000, 1'b0);
        repeat (5) @(negedge eth_rx_clk);
        check("coll_drop_next", {16'd0, drop_cnt}, 32'd45);
        wait_playing("ovl_play");
        for (int i = 0; i < 513; i++) begin
            exp = (i < 256) ? 1000 + i : (i < 512) ? 2000 + i - 256 : 3000;
            do_req("ovl_lat", 0, d);
            check("ovl_data", {16'd0, d}, 32'(exp));
        end
        stop_flag();

        // Full FIFO: 2100 words, no reads.
        start_flag();
        for (int k = 0; k < 8; k++) send_pkt(256, 256 * k, 1'b0);
        send_pkt(52, 2048, 1'b0);
        repeat (5) @(negedge eth_rx_clk);
        check("full_drop", {31'd0, (drop_cnt >= 16'd52)}, 32'd1);
        wait_playing("full_play");
        for (int i = 0; i < 2048; i++) begin
            do_req("full_lat", 0, d);
            check("full_data", {16'd0, d}, 32'(i));
        end
        stop_flag();

        // Stop with a read in flight.
        start_flag();
        send_pkt(256, 5000, 1'b0);
        send_pkt(256, 5256, 1'b0);
        wait_playing("stop_play");
        do_req("stop_lat0", 4, d);
        check("stop_first", {16'd0, d}, 32'd5000);
        @(negedge audio_clk);
        transfer_flag = 1'b0;
        @(negedge audio_clk);
        audio_req = 1'b1;
        @(negedge audio_clk);
        audio_req = 1'b0;
        check("stop_v1", {31'd0, audio_valid}, 32'd0);
        @(negedge audio_clk);
        check("stop_v2", {31'd0, audio_valid}, 32'd1);
        check("stop_data", {16'd0, audio_data}, 32'd0);
        repeat (10) @(negedge audio_clk);
        check("stop_playing", {31'd0, playing}, 32'd0);
        check("stop_underrun", {16'd0, underrun_cnt}, 32'd0);

        // Restart needs a fresh prefill; stale samples must be gone.
        start_flag();
        do_req("rs_lat", 4, d);
        check("rs_silence", {16'd0, d}, 32'd0);
        repeat (50) @(negedge audio_clk);
        check("rs_wait", {31'd0, playing}, 32'd0);
        send_pkt(256, 6000, 1'b0);
        send_pkt(256, 6256, 1'b0);
        wait_playing("rs_play");
        do_req("rs_lat2", 4, d);
        check("rs_data", {16'd0, d}, 32'd6000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_audio_depkt.md
# udp_audio_depkt

Receive-side counterpart of the audio UDP packetiser. It takes 32-bit UDP payload words from the Ethernet receive path, where each word carries one 16-bit PCM sample in bits [15:0] with bits [31:16] ignored. Samples are buffered across clock domains in an async FIFO. After a prefill threshold is reached, one sample is played out per DAC request on `audio_clk`, with underrun recovery. The block sits between the UDP RX engine and the audio DAC/I2S transmitter.

## Interface
Parameters:
- `PREFILL` (default 512): samples required in the FIFO before playback starts or resumes.
- `MAX_PKT_BYTES` (default 1024): bytes accepted per packet; words beyond `MAX_PKT_BYTES/4` in a packet are discarded.
- `FIFO_AW` (default 11): FIFO address width, giving a depth of 2048 × 16.

Ports (reset `rst_n`, asynchronous, active-low; clock `audio_clk`):
- `audio_clk`  in  1  audio/DAC clock; the primary domain.
- `rst_n`  in  1  asynchronous active-low reset for both domains. Assertion is asynchronous; deassertion is synchronised per domain.
- `eth_rx_clk`  in  1  Ethernet receive clock.
- `transfer_flag`  in  1  host start/stop control, quasi-static. It is synchronised into each domain with 2 flops. Low holds the FIFO in reset.
- `udp_rec_en`  in  1  `eth_rx_clk`; `udp_rec_data` is valid this cycle.
- `udp_rec_data`  in  32  `eth_rx_clk`; payload word.
- `udp_rec_pkt_done`  in  1  `eth_rx_clk`; 1-cycle pulse marking the end of a packet.
- `audio_req`  in  1  `audio_clk`; DAC sample strobe. Requests are at least 3 cycles apart.
- `audio_data`  out  16  played sample; reset 0.
- `audio_valid`  out  1  1-cycle pulse, `audio_data` is valid; reset 0.
- `playing`  out  1  high in the PLAY state; reset 0.
- `underrun_cnt`  out  16  `audio_clk`; saturating count of underruns; reset 0.
- `drop_cnt`  out  16  `eth_rx_clk`; saturating count of words dropped because the FIFO was full or the packet was over length; reset 0.

## Operation
Ethernet side (`eth_rx_clk`):
- `wcnt` counts words within the current packet.
- A word is written when all of the following hold:
  - `udp_rec_en`=1
  - synced `transfer_flag`=1
  - FIFO not full
  - `wcnt` < `MAX_PKT_BYTES/4`
- If `udp_rec_en`=1 and the word is not written for the full or over-length reason, `drop_cnt` increments (saturating at 0xFFFF).
- Words arriving while synced `transfer_flag`=0 are discarded silently.
- `udp_rec_pkt_done` clears `wcnt` to 0. If `udp_rec_en` is high in the same cycle, that word is evaluated against the old `wcnt` first.
- `drop_cnt` and `wcnt` clear when synced `transfer_flag`=0.

Audio side (`audio_clk`) state machine: IDLE, PREFILL, PLAY.
- IDLE:
  - Entered from reset, or from any state when synced `transfer_flag`=0.
  - FIFO read side held in reset; `underrun_cnt` cleared.
  - Moves to PREFILL when synced `transfer_flag`=1.
- PREFILL:
  - Moves to PLAY when `rd_water_level` ≥ `PREFILL`.
  - An `audio_req` here produces silence: `audio_data`=0 with `audio_valid` pulsed. The FIFO is not read.
- PLAY, on each `audio_req`:
  - FIFO not empty: assert `rd_en` and output the sample read.
  - FIFO empty: output 0 with `audio_valid` pulsed, increment `underrun_cnt` (saturating), and go to PREFILL.
- When `transfer_flag` falls, the state goes to IDLE regardless of a read in flight. That pending `audio_valid` is still issued, with `audio_data`=0.

## Timing
- `audio_req` at cycle N:
  - `rd_en` asserted at N.
  - FIFO `rd_data` valid at N+1 (1-cycle IP latency).
  - `audio_data` and `audio_valid` registered at N+2.
- The state transition from PREFILL to PLAY takes 1 cycle after the threshold is met.
- Water level is pessimistic across the CDC, with up to about 4 cycles of lag; this is acceptable.
- Eth-to-audio latency is set by the FIFO CDC (about 4 `audio_clk` cycles) plus `PREFILL` samples.
- `audio_data` holds its last value between `audio_valid` pulses.

## Structure
- Shared package `audio_pkt_pkg` holds:
  - the FSM state enum (IDLE=2'd0, PREFILL=2'd1, PLAY=2'd2)
  - `SAMPLE_W`=16
  - the default `MAX_PKT_BYTES`
- Sub-module: `fifo_audio_depkt`, a vendor async FIFO IP.
  - 16-bit write and read data, 2048 deep.
  - Provides `wr_en`, `full`, `rd_en`, `empty`, `rd_water_level[10:0]`.
  - `wr_rst` and `rd_rst` are driven by the inverse of the synced `transfer_flag` in each domain.
- Reset synchronisers and `transfer_flag` synchronisers are inline in the top level.

## Test plan
- Prefill: `transfer_flag`=1, send 2 packets of 256 words with sample values 0..511, requests every 8 cycles. Expect:
  - `playing` rises once 512 samples are buffered.
  - Output sequence is 0..511 in order.
  - Each `audio_valid` appears exactly 2 cycles after its `audio_req`.
- Underrun: after the 512 samples are played, issue 3 more requests. Expect:
  - First extra request outputs 0, `underrun_cnt`=1, state PREFILL.
  - The next 2 requests output 0 and leave `underrun_cnt` unchanged.
- Over-length packet: send 300 words in one packet. Expect 256 words written and `drop_cnt`=44.
- Full FIFO: write 2100 words with no reads. Expect `drop_cnt` ≥ 52 and the first 2048 samples intact on readback.
- Stop mid-play: drop `transfer_flag` while a request is in flight. Expect:
  - Pending output is 0.
  - State goes to IDLE, `playing`=0, FIFO empties, `underrun_cnt`=0.
  - Restart requires a fresh prefill.
- Simultaneous `udp_rec_pkt_done` and `udp_rec_en` on word 256: the word is dropped (`drop_cnt`+1), and the next packet's first word is written.
